// File: rtl/rf_pkg.sv
// Shared types and constants for the register-file writeback path.
// A writeback request is one destination register plus its data.
package rf_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;
    localparam int XLEN       = 32;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       wd;
    } wb_req_t;

    // x0 is hardwired to zero, so writes to it are architecturally void
    function automatic logic is_real_rd(input logic [REG_ADDR_W-1:0] rd);
        return rd != '0;
    endfunction

endpackage

// File: rtl/rf_writeback_arbiter_if.sv
// Bundle of the pipeline, long-latency and RF write-port signals around the arbiter.
// The master modport is the environment side and the slave modport is the arbiter side.
interface rf_writeback_arbiter_if #(
    parameter int XLEN = rf_pkg::XLEN
);
    import rf_pkg::*;

    logic                  pipe_we;
    logic [REG_ADDR_W-1:0] pipe_rd;
    logic [XLEN-1:0]       pipe_wd;

    logic                  lu_valid;
    logic                  lu_ready;
    logic [REG_ADDR_W-1:0] lu_rd;
    logic [XLEN-1:0]       lu_wd;

    logic                  iss_valid;
    logic [REG_ADDR_W-1:0] iss_rd;

    logic [NUM_REGS-1:0]   busy;
    logic                  stall_req;

    logic                  rf_we;
    logic [REG_ADDR_W-1:0] rf_wR;
    logic [XLEN-1:0]       rf_wD;

    modport master (
        output pipe_we, pipe_rd, pipe_wd,
        output lu_valid, lu_rd, lu_wd,
        output iss_valid, iss_rd,
        input  lu_ready, busy, stall_req,
        input  rf_we, rf_wR, rf_wD
    );

    modport slave (
        input  pipe_we, pipe_rd, pipe_wd,
        input  lu_valid, lu_rd, lu_wd,
        input  iss_valid, iss_rd,
        output lu_ready, busy, stall_req,
        output rf_we, rf_wR, rf_wD
    );

endinterface

// File: rtl/rf_wb_fifo.sv
// Small synchronous FIFO of writeback requests with a combinational head view.
// A push and a pop in the same cycle are both honoured even when the FIFO is full.
module rf_wb_fifo
    import rf_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  wb_req_t          push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output wb_req_t          head,
    output logic [CNT_W-1:0] count
);

    wb_req_t          mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign head    = mem[rd_ptr];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Pointers are exactly PTR_W bits wide, so incrementing wraps modulo DEPTH
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/rf_writeback_arbiter.sv
// Merges pipeline writeback (fixed priority) and buffered long-latency results onto
// the single RF write port, and tracks destinations owned by in-flight long ops.
module rf_writeback_arbiter #(
    parameter int XLEN       = rf_pkg::XLEN,
    parameter int FIFO_DEPTH = 2,
    parameter int STARVE_MAX = 4
) (
    input logic                   clk,
    input logic                   rst,
    rf_writeback_arbiter_if.slave bus
);
    import rf_pkg::*;

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int STV_W = $clog2(STARVE_MAX + 1);

    wb_req_t               push_req;
    wb_req_t               head;
    logic                  fifo_push;
    logic                  fifo_pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [CNT_W-1:0]      fifo_count;

    logic                  lu_ready;
    logic                  pipe_wr;
    logic                  starve_block;

    logic                  rf_we_q;
    logic [REG_ADDR_W-1:0] rf_wR_q;
    logic [XLEN-1:0]       rf_wD_q;
    logic [NUM_REGS-1:0]   busy_q;
    logic [NUM_REGS-1:0]   busy_next;
    logic                  stall_req_q;
    logic [STV_W-1:0]      starve_cnt;

    // Readiness comes from the registered count only, never from lu_valid
    assign lu_ready     = (fifo_count < CNT_W'(FIFO_DEPTH));
    assign fifo_push    = bus.lu_valid && lu_ready && is_real_rd(bus.lu_rd);
    assign push_req     = '{rd: bus.lu_rd, wd: bus.lu_wd};
    assign pipe_wr      = bus.pipe_we && is_real_rd(bus.pipe_rd);
    assign fifo_pop     = !pipe_wr && !fifo_empty;
    assign starve_block = fifo_full && pipe_wr;

    assign bus.lu_ready  = lu_ready;
    assign bus.busy      = busy_q;
    assign bus.stall_req = stall_req_q;
    assign bus.rf_we     = rf_we_q;
    assign bus.rf_wR     = rf_wR_q;
    assign bus.rf_wD     = rf_wD_q;

    rf_wb_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (fifo_push),
        .push_data(push_req),
        .pop      (fifo_pop),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .head     (head),
        .count    (fifo_count)
    );

    // Address and data hold their last values on idle cycles; only the enable drops
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_we_q <= 1'b0;
            rf_wR_q <= '0;
            rf_wD_q <= '0;
        end else if (pipe_wr) begin
            rf_we_q <= 1'b1;
            rf_wR_q <= bus.pipe_rd;
            rf_wD_q <= bus.pipe_wd;
        end else if (fifo_pop) begin
            rf_we_q <= 1'b1;
            rf_wR_q <= head.rd;
            rf_wD_q <= head.wd;
        end else begin
            rf_we_q <= 1'b0;
        end
    end

    // Clear is applied before set so a re-issue to the retiring register stays busy
    always_comb begin
        busy_next = busy_q;
        if (fifo_pop) begin
            busy_next[head.rd] = 1'b0;
        end
        if (bus.iss_valid && is_real_rd(bus.iss_rd)) begin
            busy_next[bus.iss_rd] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_next;
        end
    end

    // Once raised, the stall is held until the FIFO has fully drained
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_req_q <= 1'b0;
            starve_cnt  <= '0;
        end else if (stall_req_q) begin
            if (fifo_empty) begin
                stall_req_q <= 1'b0;
                starve_cnt  <= '0;
            end
        end else if (starve_block) begin
            if (starve_cnt == STV_W'(STARVE_MAX - 1)) begin
                stall_req_q <= 1'b1;
                starve_cnt  <= STV_W'(STARVE_MAX);
            end else begin
                starve_cnt <= starve_cnt + STV_W'(1);
            end
        end else begin
            starve_cnt <= '0;
        end
    end

    a_push_only_when_ready: assert property (
        @(posedge clk) disable iff (rst) fifo_push |-> lu_ready
    ) else $error("long-latency push while lu_ready is low");

    a_no_waw_on_busy: assert property (
        @(posedge clk) disable iff (rst) !(pipe_wr && busy_q[bus.pipe_rd])
    ) else $error("pipeline write to register with pending long-latency result");

    a_no_write_x0: assert property (
        @(posedge clk) disable iff (rst) rf_we_q |-> (rf_wR_q != '0)
    ) else $error("RF write enable asserted for x0");

    a_no_pipe_during_stall: assert property (
        @(posedge clk) disable iff (rst) !(stall_req_q && bus.pipe_we)
    ) else $error("pipeline writeback while stall is requested");

endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// Directed bench for rf_writeback_arbiter: reset, pipe path, LU path, conflicts,
// starvation and scoreboard set/clear, each against hand-computed values.
module tb_rf_writeback_arbiter;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    rf_writeback_arbiter_if #(.XLEN(32)) bus ();

    rf_writeback_arbiter #(
        .XLEN      (32),
        .FIFO_DEPTH(2),
        .STARVE_MAX(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs, then sample just after the next rising edge
    task automatic applyStimulus(input logic p_we, input logic [4:0] p_rd, input logic [31:0] p_wd,
                                 input logic l_v, input logic [4:0] l_rd, input logic [31:0] l_wd,
                                 input logic i_v, input logic [4:0] i_rd);
        bus.pipe_we   = p_we;
        bus.pipe_rd   = p_rd;
        bus.pipe_wd   = p_wd;
        bus.lu_valid  = l_v;
        bus.lu_rd     = l_rd;
        bus.lu_wd     = l_wd;
        bus.iss_valid = i_v;
        bus.iss_rd    = i_rd;
        @(posedge clk);
        #1;
    endtask

    task automatic applyIdle();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bus.pipe_we   = 1'b0;
        bus.pipe_rd   = '0;
        bus.pipe_wd   = '0;
        bus.lu_valid  = 1'b0;
        bus.lu_rd     = '0;
        bus.lu_wd     = '0;
        bus.iss_valid = 1'b0;
        bus.iss_rd    = '0;

        #1;
        checkOutput("reset_rf_we",  32'(bus.rf_we),     32'd0);
        checkOutput("reset_rf_wR",  32'(bus.rf_wR),     32'd0);
        checkOutput("reset_rf_wD",  bus.rf_wD,          32'd0);
        checkOutput("reset_busy",   bus.busy,           32'd0);
        checkOutput("reset_stall",  32'(bus.stall_req), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("reset_lu_ready", 32'(bus.lu_ready), 32'd1);

        $display("[TB] reset mid-stream");
        applyStimulus(1'b1, 5'd1, 32'h1, 1'b1, 5'd4, 32'h44, 1'b1, 5'd4);
        applyStimulus(1'b1, 5'd1, 32'h2, 1'b1, 5'd5, 32'h55, 1'b1, 5'd5);
        checkOutput("mid_busy_before", bus.busy,          32'h0000_0030);
        checkOutput("mid_full_ready",  32'(bus.lu_ready), 32'd0);
        bus.pipe_we   = 1'b0;
        bus.lu_valid  = 1'b0;
        bus.iss_valid = 1'b0;
        rst = 1'b1;
        #2;
        checkOutput("mid_busy_rst",  bus.busy,       32'd0);
        checkOutput("mid_rf_we_rst", 32'(bus.rf_we), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("mid_lu_ready", 32'(bus.lu_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            applyIdle();
            checkOutput("mid_no_stale_we", 32'(bus.rf_we), 32'd0);
        end
        checkOutput("mid_busy_after", bus.busy, 32'd0);

        $display("[TB] pipe only");
        applyStimulus(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        checkOutput("pipe_we", 32'(bus.rf_we), 32'd1);
        checkOutput("pipe_wR", 32'(bus.rf_wR), 32'd5);
        checkOutput("pipe_wD", bus.rf_wD,      32'hDEAD_BEEF);
        applyStimulus(1'b1, 5'd0, 32'h1111_1111, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        checkOutput("pipe_x0_we",   32'(bus.rf_we), 32'd0);
        checkOutput("pipe_x0_hold", bus.rf_wD,      32'hDEAD_BEEF);

        $display("[TB] LU path with scoreboard");
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7);
        checkOutput("lu_busy_set", bus.busy, 32'h0000_0080);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h12, 1'b0, 5'd0);
        checkOutput("lu_busy_held", bus.busy,       32'h0000_0080);
        checkOutput("lu_push_no_we", 32'(bus.rf_we), 32'd0);
        applyIdle();
        checkOutput("lu_pop_we",    32'(bus.rf_we), 32'd1);
        checkOutput("lu_pop_wR",    32'(bus.rf_wR), 32'd7);
        checkOutput("lu_pop_wD",    bus.rf_wD,      32'h12);
        checkOutput("lu_busy_clr",  bus.busy,       32'd0);

        $display("[TB] conflict and ordering");
        applyStimulus(1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44, 1'b0, 5'd0);
        checkOutput("conf_first_wR", 32'(bus.rf_wR), 32'd3);
        checkOutput("conf_first_wD", bus.rf_wD,      32'h33);
        applyIdle();
        checkOutput("conf_second_wR", 32'(bus.rf_wR), 32'd4);
        checkOutput("conf_second_wD", bus.rf_wD,      32'h44);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd8, 32'h88, 1'b0, 5'd0);
        checkOutput("order_push_no_we", 32'(bus.rf_we), 32'd0);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h99, 1'b0, 5'd0);
        checkOutput("order_x8_wR", 32'(bus.rf_wR), 32'd8);
        checkOutput("order_x8_wD", bus.rf_wD,      32'h88);
        applyIdle();
        checkOutput("order_x9_wR", 32'(bus.rf_wR), 32'd9);
        checkOutput("order_x9_wD", bus.rf_wD,      32'h99);
        applyIdle();
        checkOutput("order_drained_we", 32'(bus.rf_we), 32'd0);

        $display("[TB] full and starvation");
        applyStimulus(1'b1, 5'd1, 32'h1, 1'b1, 5'd10, 32'hA0, 1'b0, 5'd0);
        applyStimulus(1'b1, 5'd1, 32'h2, 1'b1, 5'd11, 32'hB1, 1'b0, 5'd0);
        checkOutput("starve_lu_ready", 32'(bus.lu_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 5'd1, 32'h10 + 32'(i), 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
            checkOutput("starve_not_yet", 32'(bus.stall_req), 32'd0);
        end
        applyStimulus(1'b1, 5'd1, 32'h20, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        checkOutput("starve_stall_on", 32'(bus.stall_req), 32'd1);
        checkOutput("starve_still_full", 32'(bus.lu_ready), 32'd0);
        applyIdle();
        checkOutput("drain_x10_wR", 32'(bus.rf_wR), 32'd10);
        checkOutput("drain_x10_wD", bus.rf_wD,      32'hA0);
        applyIdle();
        checkOutput("drain_x11_wR",   32'(bus.rf_wR),     32'd11);
        checkOutput("drain_x11_wD",   bus.rf_wD,          32'hB1);
        checkOutput("drain_stall_hi", 32'(bus.stall_req), 32'd1);
        applyIdle();
        checkOutput("drain_stall_off", 32'(bus.stall_req), 32'd0);
        checkOutput("drain_idle_we",   32'(bus.rf_we),     32'd0);

        $display("[TB] same-cycle set and clear, x0 result");
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd12);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd12, 32'hC, 1'b0, 5'd0);
        checkOutput("setclr_pending", bus.busy, 32'h0000_1000);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd12);
        checkOutput("setclr_busy_kept", bus.busy,       32'h0000_1000);
        checkOutput("setclr_pop_wR",    32'(bus.rf_wR), 32'd12);
        checkOutput("setclr_pop_wD",    bus.rf_wD,      32'hC);
        checkOutput("x0_ready", 32'(bus.lu_ready), 32'd1);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'hFF, 1'b0, 5'd0);
        checkOutput("x0_accept_no_we", 32'(bus.rf_we),    32'd0);
        checkOutput("x0_ready_after",  32'(bus.lu_ready), 32'd1);
        applyIdle();
        checkOutput("x0_never_written", 32'(bus.rf_we), 32'd0);
        checkOutput("x0_busy_same",     bus.busy,       32'h0000_1000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
